// File: rtl/ervp_product_accumulator.sv
// ---------------------------------------------------------------------------
// ervp_product_accumulator
//
// Pipelined signed multiply-accumulate stage. Operand pairs arrive on a
// valid/ready handshake, each full-width signed product is registered (P),
// then sign-extended and summed into a guarded accumulator. A beat marked
// last closes the group: the sum, beat count and overflow flag are presented
// on a second valid/ready handshake and the accumulator restarts from zero.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high; a valid producer holds valid and its payload
// stable until that edge.
//
// Configuration macro:
//   ERVP_PRODUCT_ACCUMULATOR_SATURATION_EN  defined   -> clamp on overflow
//                                            undefined -> two's-complement wrap
//
// Ports:
//   clk, rstnn          clock (rising edge) / async active-low reset
//   clear               synchronous group abort (drops P and partial sum)
//   in_valid/in_ready   operand beat handshake
//   in_last             beat closes the current group
//   in_multiplicand     signed operand, BW_MULTIPLICAND bits
//   in_multiplier       signed operand, BW_MULTIPLIER bits
//   out_valid/out_ready result handshake
//   out_result          signed group sum, BW_ACC bits
//   out_count           beats in group, wraps modulo 2^BW_COUNT
//   out_overflow        group sum left the signed BW_ACC range
// ---------------------------------------------------------------------------
module ervp_product_accumulator #(
   parameter int BW_MULTIPLICAND = 32,
   parameter int BW_MULTIPLIER   = 32,
   parameter int BW_ACC          = 72,
   parameter int BW_COUNT        = 16,
   parameter int USE_LIBRARY     = 1
) (
   input  logic                       clk,
   input  logic                       rstnn,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_last,
   input  logic [BW_MULTIPLICAND-1:0] in_multiplicand,
   input  logic [BW_MULTIPLIER-1:0]   in_multiplier,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BW_ACC-1:0]          out_result,
   output logic [BW_COUNT-1:0]        out_count,
   output logic                       out_overflow
);

   localparam int BW_PRODUCT = BW_MULTIPLICAND + BW_MULTIPLIER;
   localparam logic [BW_ACC-1:0] ACC_MAX = {1'b0, {(BW_ACC-1){1'b1}}};
   localparam logic [BW_ACC-1:0] ACC_MIN = {1'b1, {(BW_ACC-1){1'b0}}};

   logic                  en;
   logic [BW_PRODUCT-1:0] product_comb;
   logic [BW_PRODUCT-1:0] p_reg;
   logic                  p_valid;
   logic                  p_last;
   logic [BW_ACC-1:0]     acc;
   logic [BW_ACC-1:0]     p_ext;
   logic [BW_ACC-1:0]     sum_raw;
   logic [BW_ACC-1:0]     sum;
   logic [BW_COUNT-1:0]   cnt;
   logic [BW_COUNT-1:0]   cnt_next;
   logic                  ovf;
   logic                  step_ovf;
   logic                  step;

   // The whole pipe advances only when the result slot is free or being taken.
   assign en       = ~out_valid | out_ready;
   assign in_ready = en & ~clear;
   assign step     = en & p_valid & ~clear;

   ERVP_MULTIPLIER #(
      .BW_MULTIPLICAND (BW_MULTIPLICAND),
      .BW_MULTIPLIER   (BW_MULTIPLIER),
      .USE_LIBRARY     (USE_LIBRARY)
   ) i_multiplier (
      .multiplicand (in_multiplicand),
      .multiplier   (in_multiplier),
      .product      (product_comb)
   );

   assign p_ext    = BW_ACC'($signed(p_reg));
   assign sum_raw  = acc + p_ext;
   assign cnt_next = cnt + BW_COUNT'(1);
   // Signed overflow: both addends share a sign the sum does not.
   assign step_ovf = (acc[BW_ACC-1] == p_ext[BW_ACC-1]) &&
                     (sum_raw[BW_ACC-1] != acc[BW_ACC-1]);

`ifdef ERVP_PRODUCT_ACCUMULATOR_SATURATION_EN
   // Clamp toward the sign of the addends; later adds continue from the clamp.
   assign sum = step_ovf ? (acc[BW_ACC-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
   assign sum = sum_raw;
`endif

   // Product register stage.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         p_valid <= 1'b0;
         p_last  <= 1'b0;
         p_reg   <= '0;
      end else if (clear) begin
         p_valid <= 1'b0;
      end else if (en) begin
         p_valid <= in_valid;
         if (in_valid) begin
            p_last <= in_last;
            p_reg  <= product_comb;
         end
      end
   end

   // Accumulator, beat counter and sticky overflow for the open group.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (step) begin
         if (p_last) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
         end else begin
            acc <= sum;
            cnt <= cnt_next;
            ovf <= ovf | step_ovf;
         end
      end
   end

   // Result slot: a new result may replace the one taken in the same cycle.
   // clear leaves a pending result untouched.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (step && p_last) begin
            out_valid    <= 1'b1;
            out_result   <= sum;
            out_count    <= cnt_next;
            out_overflow <= ovf | step_ovf;
         end
      end
   end

endmodule

// ---------------------------------------------------------------------------
// ERVP_MULTIPLIER
//
// Full-width signed multiplier (combinational).
//   multiplicand  signed, BW_MULTIPLICAND bits
//   multiplier    signed, BW_MULTIPLIER bits
//   product       signed, BW_MULTIPLICAND+BW_MULTIPLIER bits
// USE_LIBRARY != 0 maps onto the synthesis tool's multiplier; otherwise a
// plain shift-add form is built where the multiplier MSB carries negative
// weight (two's complement).
// ---------------------------------------------------------------------------
module ERVP_MULTIPLIER #(
   parameter int BW_MULTIPLICAND = 32,
   parameter int BW_MULTIPLIER   = 32,
   parameter int USE_LIBRARY     = 1
) (
   input  logic [BW_MULTIPLICAND-1:0]               multiplicand,
   input  logic [BW_MULTIPLIER-1:0]                 multiplier,
   output logic [BW_MULTIPLICAND+BW_MULTIPLIER-1:0] product
);

   localparam int BW_P = BW_MULTIPLICAND + BW_MULTIPLIER;

   logic [BW_P-1:0] a_ext;
   logic [BW_P-1:0] b_ext;

   assign a_ext = BW_P'($signed(multiplicand));
   assign b_ext = BW_P'($signed(multiplier));

   generate
      if (USE_LIBRARY != 0) begin : g_library
         // Low BW_P bits of the extended product equal the signed product.
         assign product = a_ext * b_ext;
      end else begin : g_shift_add
         logic [BW_P-1:0] partial;
         always_comb begin
            partial = '0;
            for (int i = 0; i < BW_MULTIPLIER; i++) begin
               if (multiplier[i]) begin
                  if (i == BW_MULTIPLIER-1) partial = partial - (a_ext << i);
                  else                      partial = partial + (a_ext << i);
               end
            end
         end
         assign product = partial;
      end
   endgenerate

endmodule

// File: tb/tb_ervp_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ervp_product_accumulator
//
// Bench for ervp_product_accumulator: a 72-bit-accumulator instance driven
// from a vector table, random groups and hand-written corner sequences, and a
// 64-bit-accumulator instance for the overflow/saturation case.
// Expected results are pushed to exp_q when the closing beat is driven and
// popped by the monitor when the DUT transfers a result.
// ---------------------------------------------------------------------------
module tb_ervp_product_accumulator;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstnn;
   logic clear;
   always #5 clk = ~clk;

   // ---------------- main DUT (BW_ACC = 72) ----------------
   logic        in_valid, in_ready, in_last;
   logic [31:0] in_a, in_b;
   logic        out_valid, out_ready;
   logic [71:0] out_result;
   logic [15:0] out_count;
   logic        out_overflow;

   ervp_product_accumulator #(
      .BW_MULTIPLICAND (32), .BW_MULTIPLIER (32), .BW_ACC (72),
      .BW_COUNT (16), .USE_LIBRARY (1)
   ) dut (
      .clk (clk), .rstnn (rstnn), .clear (clear),
      .in_valid (in_valid), .in_ready (in_ready), .in_last (in_last),
      .in_multiplicand (in_a), .in_multiplier (in_b),
      .out_valid (out_valid), .out_ready (out_ready),
      .out_result (out_result), .out_count (out_count),
      .out_overflow (out_overflow)
   );

   // ---------------- narrow DUT (BW_ACC = 64) ----------------
   logic        v64, r64, l64;
   logic [31:0] a64, b64;
   logic        ov64;
   logic [63:0] res64;
   logic [15:0] cnt64;
   logic        of64;

   ervp_product_accumulator #(
      .BW_MULTIPLICAND (32), .BW_MULTIPLIER (32), .BW_ACC (64),
      .BW_COUNT (16), .USE_LIBRARY (0)
   ) dut64 (
      .clk (clk), .rstnn (rstnn), .clear (clear),
      .in_valid (v64), .in_ready (r64), .in_last (l64),
      .in_multiplicand (a64), .in_multiplier (b64),
      .out_valid (ov64), .out_ready (1'b1),
      .out_result (res64), .out_count (cnt64),
      .out_overflow (of64)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [88:0] exp_q[$];   // {overflow, count[15:0], result[71:0]}

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [88:0] pack_exp(input logic [71:0] r, input logic [15:0] c,
                                             input logic o);
      return {o, c, r};
   endfunction

   always @(negedge clk) begin
      if (rstnn && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got %0h required no result", out_result);
         end else begin
            logic [88:0] e;
            e = exp_q.pop_front();
            check("result", out_result, e[71:0]);
            check("count", 72'(out_count), 72'(e[87:72]));
            check("overflow", 72'(out_overflow), 72'(e[88]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+#1; returns at posedge+#1 just after acceptance.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
      int   waitc;
      logic ok;
      in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
      waitc = 0;
      forever begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         if (ok) break;
         waitc++;
         if (waitc > 50) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 required 1 within 50 cycles");
            break;
         end
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Returns at a negedge where out_valid is high (or after the budget).
   task automatic wait_out(output int n);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL out_valid_timeout: got out_valid=0 required 1 within 20 cycles");
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        last;
      logic [71:0] exp_result;
      logic [15:0] exp_count;
      logic        exp_ovf;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs[NV];

   initial begin
      int          n;
      logic [71:0] model_sum;

      // 1*2 + 3*4 + (-5)*6 + 7*(-8) = 2 + 12 - 30 - 56 = -72
      vecs[0] = '{32'sd1,  32'sd2,  1'b0, 72'd0, 16'd0, 1'b0};
      vecs[1] = '{32'sd3,  32'sd4,  1'b0, 72'd0, 16'd0, 1'b0};
      vecs[2] = '{-32'sd5, 32'sd6,  1'b0, 72'd0, 16'd0, 1'b0};
      vecs[3] = '{32'sd7,  -32'sd8, 1'b1, -72'sd72, 16'd4, 1'b0};
      // (2^31-1)^2 = 2^62 - 2^32 + 1
      vecs[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 72'h00_3FFF_FFFF_0000_0001, 16'd1, 1'b0};
      // -2^31*1 + (-1)*(-1) = -2147483647
      vecs[5] = '{32'h8000_0000, 32'sd1, 1'b0, 72'd0, 16'd0, 1'b0};
      vecs[6] = '{-32'sd1, -32'sd1, 1'b1, -72'sd2147483647, 16'd2, 1'b0};
      // zero operand single-beat group
      vecs[7] = '{32'sd0, 32'sd12345, 1'b1, 72'd0, 16'd1, 1'b0};
      // -2^31 * -2^31 = 2^62, single beat, fits in 72 bits
      vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 72'h00_4000_0000_0000_0000, 16'd1, 1'b0};

      rstnn = 1'b0; clear = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
      v64 = 1'b0; l64 = 1'b0; a64 = '0; b64 = '0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("rst_out_valid", 72'(out_valid), 72'd0);
      check("rst_out_result", out_result, 72'd0);
      check("rst_out_count", 72'(out_count), 72'd0);
      check("rst_out_overflow", 72'(out_overflow), 72'd0);
      tick(1);
      rstnn = 1'b1;
      @(negedge clk);
      check("rel_in_ready", 72'(in_ready), 72'd1);
      check("rel_out_valid", 72'(out_valid), 72'd0);
      tick(1);

      // ---- single beat latency: 3 * -4 = -12 ----
      exp_q.push_back(pack_exp(-72'sd12, 16'd1, 1'b0));
      send(32'sd3, -32'sd4, 1'b1);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 10) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      // one edge after the accepting edge loads P, the next loads out_valid
      check("latency_edges", 72'(n), 72'd1);
      tick(1);

      // ---- table, back-to-back ----
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].last)
            exp_q.push_back(pack_exp(vecs[i].exp_result, vecs[i].exp_count, vecs[i].exp_ovf));
         send(vecs[i].a, vecs[i].b, vecs[i].last);
      end
      tick(4);

      // ---- random groups with a small model ----
      for (int g = 0; g < 5; g++) begin
         int nb;
         nb = int'($urandom_range(4, 1));
         model_sum = '0;
         for (int k = 0; k < nb; k++) begin
            int     ra, rb;
            longint pr;
            ra = int'($urandom_range(2000, 0)) - 1000;
            rb = int'($urandom_range(2000, 0)) - 1000;
            pr = longint'(ra) * longint'(rb);
            model_sum = model_sum + 72'(pr);
            if (k == nb - 1) exp_q.push_back(pack_exp(model_sum, 16'(nb), 1'b0));
            send(32'(ra), 32'(rb), (k == nb - 1));
         end
      end
      tick(4);

      // ---- backpressure: 2*3 = 6 held for 5 cycles ----
      out_ready = 1'b0;
      exp_q.push_back(pack_exp(72'sd6, 16'd1, 1'b0));
      send(32'sd2, 32'sd3, 1'b1);
      wait_out(n);
      for (int c = 0; c < 5; c++) begin
         check("bp_in_ready", 72'(in_ready), 72'd0);
         check("bp_out_valid", 72'(out_valid), 72'd1);
         check("bp_result_stable", out_result, 72'sd6);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      exp_q.push_back(pack_exp(72'sd20, 16'd1, 1'b0));
      send(32'sd4, 32'sd5, 1'b1);
      tick(4);

      // ---- clear after two of four beats ----
      send(32'sd10, 32'sd10, 1'b0);
      send(32'sd20, 32'sd20, 1'b0);
      clear = 1'b1;
      in_valid = 1'b1; in_a = 32'sd99; in_b = 32'sd99; in_last = 1'b1;
      @(negedge clk);
      check("clear_in_ready", 72'(in_ready), 72'd0);
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      exp_q.push_back(pack_exp(72'sd4, 16'd1, 1'b0));
      send(32'sd2, 32'sd2, 1'b1);
      tick(4);

      // ---- 64-bit accumulator overflow: 2^62 + 2^62 ----
      @(negedge clk);
      check("acc64_in_ready", 72'(r64), 72'd1);
      @(posedge clk);
      #1;
      v64 = 1'b1; a64 = 32'h8000_0000; b64 = 32'h8000_0000; l64 = 1'b0;
      @(posedge clk);
      #1;
      l64 = 1'b1;
      @(posedge clk);
      #1;
      v64 = 1'b0; l64 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!ov64 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("acc64_out_valid", 72'(ov64), 72'd1);
`ifdef ERVP_PRODUCT_ACCUMULATOR_SATURATION_EN
      check("acc64_result", 72'(res64), 72'h00_7FFF_FFFF_FFFF_FFFF);
`else
      check("acc64_result", 72'(res64), 72'h00_8000_0000_0000_0000);
`endif
      check("acc64_count", 72'(cnt64), 72'd2);
      check("acc64_overflow", 72'(of64), 72'd1);
      tick(2);

      // ---- async reset mid-group with a result pending ----
      out_ready = 1'b0;
      send(32'sd5, 32'sd5, 1'b1);      // result 25, never taken
      send(32'sd3, 32'sd3, 1'b0);      // open group beat sits in P
      #1;
      rstnn = 1'b0;
      #1;
      check("arst_out_valid", 72'(out_valid), 72'd0);
      check("arst_out_result", out_result, 72'd0);
      check("arst_out_count", 72'(out_count), 72'd0);
      check("arst_out_overflow", 72'(out_overflow), 72'd0);
      tick(2);
      rstnn = 1'b1;
      out_ready = 1'b1;
      tick(1);
      exp_q.push_back(pack_exp(72'sd7, 16'd1, 1'b0));
      send(32'sd1, 32'sd7, 1'b1);

      // ---- drain ----
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain_queue_empty", 72'(exp_q.size()), 72'd0);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
